// File: rtl/tc_clk_gate_ctrl.sv
// Enable sequencer for a shared gated clock domain: wake-up delay before acking
// requesters, idle hysteresis before gating the clock back off.
//
// state | meaning
// OFF   | clock gated, waiting for any request
// WAKE  | enable asserted, counting out the wake-up delay
// ON    | gated clock stable, requesters acknowledged
// HOLD  | no requests, counting idle hysteresis before gating off
module tc_clk_gate_ctrl #(
  parameter int NumReq     = 4,
  parameter int WakeCycles = 4,
  parameter int IdleCycles = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              force_on_i,
  output logic [NumReq-1:0] ack_o,
  output logic              clk_en_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam int MaxCycles = (WakeCycles > IdleCycles) ? WakeCycles : IdleCycles;
  localparam int CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] WakeLoad = CntW'(WakeCycles - 1);
  localparam logic [CntW-1:0] IdleLoad = CntW'(IdleCycles - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clk_en_q, clk_en_d;
  logic            any_req;

  assign any_req = (|req_i) | force_on_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      OFF: begin
        if (any_req) begin
          state_d = WAKE;
          cnt_d   = WakeLoad;
        end
      end
      WAKE: begin
        // A request dropping here does not abort the wake; we finish and fall to HOLD.
        if (cnt_q == '0) begin
          if (any_req) begin
            state_d = ON;
          end else begin
            state_d = HOLD;
            cnt_d   = IdleLoad;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ON: begin
        if (!any_req) begin
          state_d = HOLD;
          cnt_d   = IdleLoad;
        end
      end
      HOLD: begin
        if (any_req) begin
          state_d = ON;
        end else if (cnt_q == '0) begin
          state_d = OFF;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
    endcase
    clk_en_d = (state_d != OFF);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
    end
  end

  // Enable comes straight from a flop so the gating cell never sees a glitch.
  assign clk_en_o = clk_en_q;
  assign state_o  = state_q;
  assign ack_o    = req_i & {NumReq{state_q == ON}};

endmodule

// File: tb/tb_tc_clk_gate_ctrl.sv
// Directed bench for tc_clk_gate_ctrl with default parameters (4 req, wake 4, idle 16).
// Each check compares {state_o, clk_en_o, ack_o} against a hand-derived value.
module tb_tc_clk_gate_ctrl;

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] req_i = 4'b0000;
  logic       force_on_i = 1'b0;
  logic [3:0] ack_o;
  logic       clk_en_o;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  tc_clk_gate_ctrl #(
    .NumReq    (4),
    .WakeCycles(4),
    .IdleCycles(16)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .force_on_i(force_on_i),
    .ack_o     (ack_o),
    .clk_en_o  (clk_en_o),
    .state_o   (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge: start of a new cycle.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Leaves the bench at the start of a cycle in OFF with rst_i low.
  task automatic do_reset();
    rst_i = 1'b1;
    req_i = 4'b0000;
    force_on_i = 1'b0;
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst_i = 1'b1;
    req_i = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (c == 3) rst_i = 1'b0;
      #2;
      obs = {state_o, clk_en_o, ack_o};
      n_checks++;
      if (obs !== 7'b0) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %b exp %b", c, obs, 7'b0);
      end
    end
  endtask

  task automatic test_wake_latency();
    logic [6:0] obs, e;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) cyc();
      if (c == 0) req_i = 4'b0001;
      #2;
      if (c == 0)      e = {S_OFF, 1'b0, 4'b0000};
      else if (c <= 4) e = {S_WAKE, 1'b1, 4'b0000};
      else             e = {S_ON, 1'b1, 4'b0001};
      obs = {state_o, clk_en_o, ack_o};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL wake_latency cyc %0d: got %b exp %b", c, obs, e);
      end
    end
  endtask

  // r = cycle in which req_i[2] is raised after the drop at cycle 10 (0 = never).
  task automatic test_idle(input int r);
    logic [6:0] obs, e;
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) cyc();
      if (c == 0)  req_i = 4'b0001;
      if (c == 10) req_i = 4'b0000;
      if (r != 0 && c == r) req_i = 4'b0100;
      #2;
      if (c == 0)                             e = {S_OFF, 1'b0, 4'b0000};
      else if (c <= 4)                        e = {S_WAKE, 1'b1, 4'b0000};
      else if (c <= 9)                        e = {S_ON, 1'b1, 4'b0001};
      else if (c == 10)                       e = {S_ON, 1'b1, 4'b0000};
      else if (r != 0 && r <= 26 && c > r)    e = {S_ON, 1'b1, 4'b0100};
      else if (c <= 26)                       e = {S_HOLD, 1'b1, 4'b0000};
      else if (r == 27 && c >= 32)            e = {S_ON, 1'b1, 4'b0100};
      else if (r == 27 && c >= 28)            e = {S_WAKE, 1'b1, 4'b0000};
      else                                    e = {S_OFF, 1'b0, 4'b0000};
      obs = {state_o, clk_en_o, ack_o};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL idle(r=%0d) cyc %0d: got %b exp %b", r, c, obs, e);
      end
    end
  endtask

  task automatic test_multi_req();
    logic [3:0] req_tab [13];
    logic [6:0] exp_tab [13];
    logic [6:0] obs;
    req_tab = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1010,
                4'b1010, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    exp_tab = '{{S_OFF, 1'b0, 4'b0000}, {S_WAKE, 1'b1, 4'b0000}, {S_WAKE, 1'b1, 4'b0000},
                {S_WAKE, 1'b1, 4'b0000}, {S_WAKE, 1'b1, 4'b0000}, {S_ON, 1'b1, 4'b0010},
                {S_ON, 1'b1, 4'b1010}, {S_ON, 1'b1, 4'b1010}, {S_ON, 1'b1, 4'b1000},
                {S_ON, 1'b1, 4'b1000}, {S_ON, 1'b1, 4'b0000}, {S_HOLD, 1'b1, 4'b0000},
                {S_HOLD, 1'b1, 4'b0000}};
    do_reset();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) cyc();
      req_i = req_tab[c];
      #2;
      obs = {state_o, clk_en_o, ack_o};
      n_checks++;
      if (obs !== exp_tab[c]) begin
        n_fail++;
        $display("FAIL multi_req cyc %0d: got %b exp %b", c, obs, exp_tab[c]);
      end
    end
  endtask

  task automatic test_drop_during_wake();
    logic [6:0] obs, e;
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      if (c > 0) cyc();
      req_i = (c == 0) ? 4'b0001 : 4'b0000;
      #2;
      if (c == 0)       e = {S_OFF, 1'b0, 4'b0000};
      else if (c <= 4)  e = {S_WAKE, 1'b1, 4'b0000};
      else if (c <= 20) e = {S_HOLD, 1'b1, 4'b0000};
      else              e = {S_OFF, 1'b0, 4'b0000};
      obs = {state_o, clk_en_o, ack_o};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL drop_wake cyc %0d: got %b exp %b", c, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [6:0] obs, e;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) cyc();
      req_i = 4'b1111;
      if (c == 6) rst_i = 1'b1;
      if (c == 8) rst_i = 1'b0;
      #2;
      if (c == 0)       e = {S_OFF, 1'b0, 4'b0000};
      else if (c <= 4)  e = {S_WAKE, 1'b1, 4'b0000};
      else if (c <= 6)  e = {S_ON, 1'b1, 4'b1111};
      else if (c <= 8)  e = {S_OFF, 1'b0, 4'b0000};
      else if (c <= 12) e = {S_WAKE, 1'b1, 4'b0000};
      else              e = {S_ON, 1'b1, 4'b1111};
      obs = {state_o, clk_en_o, ack_o};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: got %b exp %b", c, obs, e);
      end
    end
  endtask

  task automatic test_force_on();
    logic [6:0] obs, e;
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) cyc();
      force_on_i = (c < 13);
      req_i = (c == 10) ? 4'b0001 : 4'b0000;
      #2;
      if (c == 0)       e = {S_OFF, 1'b0, 4'b0000};
      else if (c <= 4)  e = {S_WAKE, 1'b1, 4'b0000};
      else if (c == 10) e = {S_ON, 1'b1, 4'b0001};
      else if (c <= 13) e = {S_ON, 1'b1, 4'b0000};
      else              e = {S_HOLD, 1'b1, 4'b0000};
      obs = {state_o, clk_en_o, ack_o};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL force_on cyc %0d: got %b exp %b", c, obs, e);
      end
    end
    force_on_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wake_latency();
    test_idle(0);
    test_idle(20);
    test_idle(11);
    test_idle(26);
    test_idle(27);
    test_multi_req();
    test_drop_during_wake();
    test_reset_mid_op();
    test_force_on();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
